dest_collector: RTL and testbench

DEST_COLLECTOR -- requirements
Module: dest_collector

---
 rtl/dest_collector_pkg.sv | 18 +
 rtl/dest_collector_rr_arb2.sv | 21 ++
 rtl/dest_collector.sv | 143 ++++++++++++++
 tb/tb_dest_collector.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dest_collector_pkg.sv
// Shared constants for the destination collector: FSM encodings,
// source identifiers and the default destination word width.
package dest_collector_pkg;

  // Destination FIFO word width used when the instantiation does not override it.
  localparam int WORD_SIZE_DEF = 6;

  // Collector FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_CAP  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Source identifiers as carried on src_out and held as the last grant.
  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

endpackage

// File: rtl/dest_collector_rr_arb2.sv
// Two-way round-robin selector. With both requests present the source
// opposite the previous grant wins; with one request that source wins.
module rr_arb2
  import dest_collector_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  // Pick the winner; the value with no request is a don't-care (D0).
  always_comb begin
    grant = SRC_D0;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = SRC_D1;
    end
  end

endmodule

// File: rtl/dest_collector.sv
// Collects words from two destination FIFOs (D0, D1) one at a time,
// presents each on a valid/ready output and counts deliveries per source.
//
// Handshake: valid_out is high only in HOLD; a word transfers on the rising
// edge where valid_out and out_ready are both 1. data_out and src_out do not
// change while valid_out is high and out_ready is low.
module dest_collector
  import dest_collector_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 empty_d0,
  input  logic                 empty_d1,
  input  logic [WORD_SIZE-1:0] data_d0,
  input  logic [WORD_SIZE-1:0] data_d1,
  output logic                 pop_d0,
  output logic                 pop_d1,
  input  logic                 out_ready,
  output logic                 valid_out,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 src_out,
  output logic [CNT_W-1:0]     cnt_d0,
  output logic [CNT_W-1:0]     cnt_d1,
  output logic                 route_err
);

  logic [1:0]           state_q, state_d;
  logic                 sel_q, sel_d;     // source of the read in flight
  logic                 last_q, last_d;   // last granted source
  logic                 arm_q, arm_d;     // low for the first cycle out of reset
  logic                 pop0_q, pop0_d;
  logic                 pop1_q, pop1_d;
  logic [WORD_SIZE-1:0] dout_q, dout_d;
  logic                 src_q, src_d;
  logic [CNT_W-1:0]     cnt0_q, cnt0_d;
  logic [CNT_W-1:0]     cnt1_q, cnt1_d;
  logic                 err_q, err_d;

  logic [1:0]           req;
  logic                 grant;

  assign req = {~empty_d1, ~empty_d0};

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_q),
    .grant      (grant)
  );

  // Next-state logic: one read at a time, empties looked at only in IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    arm_d   = 1'b1;
    pop0_d  = 1'b0;
    pop1_d  = 1'b0;
    dout_d  = dout_q;
    src_d   = src_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arm_q && (req != 2'b00)) begin
          sel_d   = grant;
          last_d  = grant;
          pop0_d  = (grant == SRC_D0);
          pop1_d  = (grant == SRC_D1);
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        // FIFO read data is valid the cycle after the pop.
        dout_d  = (sel_q == SRC_D1) ? data_d1 : data_d0;
        src_d   = sel_q;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (src_q == SRC_D1) begin
            cnt1_d = cnt1_q + CNT_W'(1);
          end else begin
            cnt0_d = cnt0_q + CNT_W'(1);
          end
          // Bit 4 of each word names the destination it was routed to.
          if (dout_q[4] != src_q) begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      sel_q   <= SRC_D0;
      last_q  <= SRC_D1;
      arm_q   <= 1'b0;
      pop0_q  <= 1'b0;
      pop1_q  <= 1'b0;
      dout_q  <= '0;
      src_q   <= SRC_D0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      arm_q   <= arm_d;
      pop0_q  <= pop0_d;
      pop1_q  <= pop1_d;
      dout_q  <= dout_d;
      src_q   <= src_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      err_q   <= err_d;
    end
  end

  assign pop_d0    = pop0_q;
  assign pop_d1    = pop1_q;
  assign valid_out = (state_q == ST_HOLD);
  assign data_out  = dout_q;
  assign src_out   = src_q;
  assign cnt_d0    = cnt0_q;
  assign cnt_d1    = cnt1_q;
  assign route_err = err_q;

endmodule

// File: tb/tb_dest_collector.sv
// Bench for dest_collector: FIFO models for D0/D1, a round-robin reference
// model producing the expected delivery order, directed vectors and
// randomized traffic with random downstream stalls.
module tb_dest_collector;

  localparam int WS = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          empty_d0, empty_d1;
  logic [WS-1:0] data_d0, data_d1;
  logic          pop_d0, pop_d1;
  logic          out_ready;
  logic          valid_out;
  logic [WS-1:0] data_out;
  logic          src_out;
  logic [CW-1:0] cnt_d0, cnt_d1;
  logic          route_err;

  // Clock.
  always #5 clk = ~clk;

  dest_collector #(.WORD_SIZE(WS), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .empty_d0  (empty_d0),
    .empty_d1  (empty_d1),
    .data_d0   (data_d0),
    .data_d1   (data_d1),
    .pop_d0    (pop_d0),
    .pop_d1    (pop_d1),
    .out_ready (out_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .src_out   (src_out),
    .cnt_d0    (cnt_d0),
    .cnt_d1    (cnt_d1),
    .route_err (route_err)
  );

  typedef struct {
    logic          has0;
    logic [WS-1:0] w0;
    logic          has1;
    logic [WS-1:0] w1;
    logic [CW-1:0] exp_c0;
    logic [CW-1:0] exp_c1;
    logic          exp_err;
    logic [WS:0]   exp_first;   // {src, data} of the first delivery
  } vec_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            last_pop = -100;
  int            rdy_mode = 0;   // 0: always ready, 1: random, 2: never
  logic [WS-1:0] q0[$];
  logic [WS-1:0] q1[$];
  logic [WS:0]   exp_q[$];
  logic [WS:0]   got_q[$];
  logic [CW-1:0] m_cnt0, m_cnt1;
  logic          m_err;
  logic          prev_valid, prev_hs, prev_src;
  logic [WS-1:0] prev_data;
  vec_t          vecs[6];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic upd_empty();
    empty_d0 = (q0.size() == 0);
    empty_d1 = (q1.size() == 0);
  endtask

  // Reference model: drain both FIFO contents in round-robin order, D0 first.
  task automatic build_exp();
    int   i0;
    int   i1;
    logic last;
    logic pick;
    i0 = 0;
    i1 = 0;
    last = 1'b1;
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) pick = ~last;
      else pick = (i1 < q1.size());
      if (pick) begin
        exp_q.push_back({1'b1, q1[i1]});
        i1++;
      end else begin
        exp_q.push_back({1'b0, q0[i0]});
        i0++;
      end
      last = pick;
    end
  endtask

  // One cycle: FIFO model response, ready policy, protocol checks, scoreboard.
  task automatic tick();
    logic        hs;
    logic [WS:0] e;
    @(negedge clk);
    cyc++;
    if (pop_d0 && q0.size() > 0) data_d0 = q0.pop_front();
    if (pop_d1 && q1.size() > 0) data_d1 = q1.pop_front();
    upd_empty();
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (reset_L) begin
      check_eq("pop_exclusive", 32'(pop_d0 & pop_d1), 32'd0);
      check_eq("pop_while_valid", 32'((pop_d0 | pop_d1) & valid_out), 32'd0);
      if (pop_d0 | pop_d1) begin
        check_eq("pop_spacing", 32'((cyc - last_pop) >= 4), 32'd1);
        last_pop = cyc;
      end
      if (valid_out && prev_valid && !prev_hs) begin
        check_eq("hold_data_stable", 32'(data_out), 32'(prev_data));
        check_eq("hold_src_stable", 32'(src_out), 32'(prev_src));
      end
      hs = valid_out & out_ready;
      if (hs) begin
        got_q.push_back({src_out, data_out});
        check_eq("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("delivered_word", 32'({src_out, data_out}), 32'(e));
          if (e[WS]) m_cnt1 = m_cnt1 + 8'd1;
          else       m_cnt0 = m_cnt0 + 8'd1;
          if (e[4] != e[WS]) m_err = 1'b1;
        end
      end
      prev_valid = valid_out;
      prev_hs    = hs;
      prev_data  = data_out;
      prev_src   = src_out;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      last_pop   = -100;
    end
  endtask

  task automatic clear_model();
    m_cnt0 = '0;
    m_cnt1 = '0;
    m_err  = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    upd_empty();
    reset_L = 1'b0;
    tick();
    tick();
    clear_model();
  endtask

  task automatic chk_reset(input string tag);
    check_eq({tag, "_pop_d0"}, 32'(pop_d0), 32'd0);
    check_eq({tag, "_pop_d1"}, 32'(pop_d1), 32'd0);
    check_eq({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    check_eq({tag, "_data_out"}, 32'(data_out), 32'd0);
    check_eq({tag, "_src_out"}, 32'(src_out), 32'd0);
    check_eq({tag, "_cnt_d0"}, 32'(cnt_d0), 32'd0);
    check_eq({tag, "_cnt_d1"}, 32'(cnt_d1), 32'd0);
    check_eq({tag, "_route_err"}, 32'(route_err), 32'd0);
  endtask

  // Run until every expected word is delivered, within a cycle budget.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || valid_out) && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_in_budget", 32'(n < budget), 32'd1);
    tick();
    tick();
  endtask

  task automatic chk_counts(input string tag);
    check_eq({tag, "_cnt_d0"}, 32'(cnt_d0), 32'(m_cnt0));
    check_eq({tag, "_cnt_d1"}, 32'(cnt_d1), 32'(m_cnt1));
    check_eq({tag, "_route_err"}, 32'(route_err), 32'(m_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          n0;
    int          n1;
    logic [WS-1:0] hold_val;
    logic [WS:0] order[6];

    reset_L   = 1'b0;
    out_ready = 1'b1;
    data_d0   = '0;
    data_d1   = '0;
    upd_empty();
    clear_model();
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_data  = '0;
    prev_src   = 1'b0;

    vecs[0] = '{1'b1, 6'h05, 1'b0, 6'h00, 8'd1, 8'd0, 1'b0, 7'h05};
    vecs[1] = '{1'b0, 6'h00, 1'b1, 6'h13, 8'd0, 8'd1, 1'b0, 7'h53};
    vecs[2] = '{1'b1, 6'h01, 1'b1, 6'h11, 8'd1, 8'd1, 1'b0, 7'h01};
    vecs[3] = '{1'b1, 6'h10, 1'b0, 6'h00, 8'd1, 8'd0, 1'b1, 7'h10};
    vecs[4] = '{1'b0, 6'h00, 1'b1, 6'h03, 8'd0, 8'd1, 1'b1, 7'h43};
    vecs[5] = '{1'b1, 6'h2a, 1'b1, 6'h1f, 8'd1, 8'd1, 1'b0, 7'h2a};

    // Directed single-word vectors.
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      chk_reset("reset");
      reset_L = 1'b1;
      if (vecs[i].has0) q0.push_back(vecs[i].w0);
      if (vecs[i].has1) q1.push_back(vecs[i].w1);
      upd_empty();
      build_exp();
      drain(60);
      check_eq("vec_first_word", 32'(got_q.size() > 0 ? got_q[0] : 7'h7f), 32'(vecs[i].exp_first));
      check_eq("vec_cnt_d0", 32'(cnt_d0), 32'(vecs[i].exp_c0));
      check_eq("vec_cnt_d1", 32'(cnt_d1), 32'(vecs[i].exp_c1));
      check_eq("vec_route_err", 32'(route_err), 32'(vecs[i].exp_err));
    end

    // Three words in each FIFO: strict alternation starting at D0.
    do_reset();
    reset_L = 1'b1;
    q0 = '{6'h01, 6'h02, 6'h03};
    q1 = '{6'h11, 6'h12, 6'h13};
    upd_empty();
    build_exp();
    drain(100);
    order = '{7'h01, 7'h51, 7'h02, 7'h52, 7'h03, 7'h53};
    check_eq("rr_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_eq("rr_order", 32'(i < got_q.size() ? got_q[i] : 7'h7f), 32'(order[i]));
    end
    check_eq("rr_cnt_d0", 32'(cnt_d0), 32'd3);
    check_eq("rr_cnt_d1", 32'(cnt_d1), 32'd3);

    // Downstream stall of 10 cycles in HOLD.
    do_reset();
    reset_L = 1'b1;
    rdy_mode = 2;
    q0.push_back(6'h2c);
    upd_empty();
    build_exp();
    n = 0;
    while (!valid_out && n < 20) begin
      tick();
      n++;
    end
    check_eq("stall_valid_seen", 32'(valid_out), 32'd1);
    hold_val = data_out;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("stall_valid", 32'(valid_out), 32'd1);
      check_eq("stall_data", 32'(data_out), 32'h2c);
      check_eq("stall_no_pop", 32'(pop_d0 | pop_d1), 32'd0);
    end
    check_eq("stall_data_const", 32'(data_out), 32'(hold_val));
    check_eq("stall_cnt_before", 32'(cnt_d0), 32'd0);
    rdy_mode = 0;
    drain(20);
    check_eq("stall_cnt_after", 32'(cnt_d0), 32'd1);

    // Routing error is sticky across later correct words until reset.
    do_reset();
    reset_L = 1'b1;
    q0 = '{6'h10, 6'h01, 6'h02};
    upd_empty();
    build_exp();
    drain(60);
    check_eq("err_sticky", 32'(route_err), 32'd1);
    check_eq("err_cnt_d0", 32'(cnt_d0), 32'd3);
    do_reset();
    chk_reset("err_cleared");
    reset_L = 1'b1;

    // 256 words from D1 wrap its counter back to zero.
    for (int i = 0; i < 256; i++) q1.push_back(6'h10 | 6'($urandom_range(0, 15)));
    upd_empty();
    build_exp();
    drain(256 * 4 + 100);
    check_eq("wrap_cnt_d1", 32'(cnt_d1), 32'd0);
    check_eq("wrap_cnt_d0", 32'(cnt_d0), 32'd0);
    check_eq("wrap_route_err", 32'(route_err), 32'd0);

    // Reset pulse while the word is being captured.
    do_reset();
    reset_L = 1'b1;
    q0 = '{6'h05, 6'h06};
    upd_empty();
    n = 0;
    while (!pop_d0 && n < 20) begin
      tick();
      n++;
    end
    check_eq("midreset_pop_seen", 32'(pop_d0), 32'd1);
    tick();                      // CAP cycle
    reset_L = 1'b0;
    tick();
    chk_reset("midreset");
    reset_L = 1'b1;
    clear_model();
    tick();
    check_eq("midreset_no_early_pop", 32'(pop_d0 | pop_d1), 32'd0);
    build_exp();
    drain(40);
    check_eq("midreset_next_word", 32'(got_q.size() > 0 ? got_q[0] : 7'h7f), 32'h06);
    check_eq("midreset_cnt_d0", 32'(cnt_d0), 32'd1);

    // Randomized traffic with random stalls against the reference model.
    rdy_mode = 1;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      reset_L = 1'b1;
      n0 = $urandom_range(0, 12);
      n1 = $urandom_range(0, 12);
      for (int k = 0; k < n0; k++) q0.push_back(6'($urandom_range(0, 63)));
      for (int k = 0; k < n1; k++) q1.push_back(6'($urandom_range(0, 63)));
      upd_empty();
      build_exp();
      drain((n0 + n1) * 30 + 50);
      chk_counts("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
